// File: rtl/controls_w.sv
// rtl/controls_w.sv - writeback-stage regfile write sequencer with a pending multdiv result FIFO
// Optional feature macro: WB_STATUS_EN (overflow / multdiv exceptions write rstatus codes to r30).
module controls_w #(
  parameter int MD_DEPTH   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        w_valid,
  input  logic [4:0]  w_opcode,
  input  logic [4:0]  w_aluop,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_alu_result,
  input  logic [31:0] w_mem_data,
  input  logic [31:0] w_pc_plus1,
  input  logic [26:0] w_target,
  input  logic        w_ovf,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_result,
  input  logic        md_exc,
  input  logic        md_is_div,
  output logic        md_ready,
  output logic        w_stall,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data
);

  localparam int PTR_W = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int CNT_W = $clog2(MD_DEPTH + 1);
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_STAT = 5'd30;

  logic [4:0]       r_fifo_rd   [MD_DEPTH];
  logic [31:0]      r_fifo_data [MD_DEPTH];
  logic             r_fifo_exc  [MD_DEPTH];
  logic             r_fifo_div  [MD_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [STV_W-1:0] r_starve;

  logic        w_dec_wr;
  logic [4:0]  w_dec_rd;
  logic [31:0] w_dec_data;
  logic        w_w_wants;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;
  logic        w_empty;
  logic        w_full;
  logic        w_force;
  logic        w_pop;
  logic        w_push;
  logic        w_take_w;

  // W-stage decode: destination and data source of the write, if any.
  always_comb begin
    w_dec_wr   = 1'b0;
    w_dec_rd   = w_rd;
    w_dec_data = w_alu_result;
    if (w_valid) begin
      case (w_opcode)
        OP_RTYPE: w_dec_wr = (w_aluop != ALU_MUL) && (w_aluop != ALU_DIV);
        OP_ADDI:  w_dec_wr = 1'b1;
        OP_LW: begin
          w_dec_wr   = 1'b1;
          w_dec_data = w_mem_data;
        end
        OP_JAL: begin
          w_dec_wr   = 1'b1;
          w_dec_rd   = REG_RA;
          w_dec_data = w_pc_plus1;
        end
        OP_SETX: begin
          w_dec_wr   = 1'b1;
          w_dec_rd   = REG_STAT;
          w_dec_data = {5'd0, w_target};
        end
        default: w_dec_wr = 1'b0;
      endcase
`ifdef WB_STATUS_EN
      if (w_ovf) begin
        if (w_opcode == OP_RTYPE && w_aluop == ALU_ADD) begin
          w_dec_rd   = REG_STAT;
          w_dec_data = 32'd1;
        end else if (w_opcode == OP_ADDI) begin
          w_dec_rd   = REG_STAT;
          w_dec_data = 32'd2;
        end else if (w_opcode == OP_RTYPE && w_aluop == ALU_SUB) begin
          w_dec_rd   = REG_STAT;
          w_dec_data = 32'd3;
        end
      end
`endif
    end
  end

  // A write to r0 is a no-op, so it never competes for the port or stalls W.
  assign w_w_wants = w_dec_wr && (w_dec_rd != 5'd0);

  always_comb begin
    w_head_rd   = r_fifo_rd[r_rd_ptr];
    w_head_data = r_fifo_data[r_rd_ptr];
`ifdef WB_STATUS_EN
    if (r_fifo_exc[r_rd_ptr]) begin
      w_head_rd   = REG_STAT;
      w_head_data = r_fifo_div[r_rd_ptr] ? 32'd5 : 32'd4;
    end
`endif
  end

`ifndef WB_STATUS_EN
  logic w_unused_status;
  assign w_unused_status = w_ovf ^ r_fifo_exc[r_rd_ptr] ^ r_fifo_div[r_rd_ptr];
`endif

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(MD_DEPTH));
  assign w_force  = !w_empty && ((r_starve == STV_W'(STARVE_MAX)) || (w_full && w_w_wants));
  assign w_pop    = w_force || (!w_empty && !w_w_wants);
  assign w_take_w = !w_force && w_w_wants;
  assign w_stall  = w_force && w_w_wants;
  assign md_ready = !w_full;
  assign w_push   = md_valid && md_ready;

  // Entry storage needs no reset: the count/pointers alone define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= md_rd;
      r_fifo_data[r_wr_ptr] <= md_result;
      r_fifo_exc[r_wr_ptr]  <= md_exc;
      r_fifo_div[r_wr_ptr]  <= md_is_div;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      wr_en    <= 1'b0;
      wr_reg   <= 5'd0;
      wr_data  <= 32'd0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(MD_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(MD_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      if (w_pop || w_empty)
        r_starve <= '0;
      else if (w_take_w && r_starve != STV_W'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;

      if (w_pop) begin
        wr_en   <= (w_head_rd != 5'd0);
        wr_reg  <= w_head_rd;
        wr_data <= w_head_data;
      end else if (w_take_w) begin
        wr_en   <= 1'b1;
        wr_reg  <= w_dec_rd;
        wr_data <= w_dec_data;
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/controls_w.md
Name: controls_W

Overview:
- Writeback-stage control and register-file write-port sequencer for the 5-stage processor.
- Sits at the opposite end of the regfile from the decode-stage read-select controls.
- Decodes the W-stage opcode into a regfile write (destination, data source, exception status), and merges late multdiv results through a small pending FIFO.
- Owns the single regfile write port; drives one registered write per cycle.

Parameters:
- MD_DEPTH, 2, pending multdiv result FIFO entries (1..4).
- STARVE_MAX, 3, consecutive cycles a non-empty FIFO may be bypassed by pipeline writes before a forced drain.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- w_valid  in  1  W-stage holds a real instruction.
- w_opcode  in  5  W-stage opcode.
- w_aluop  in  5  ALU op field (R-type only).
- w_rd  in  5  destination field.
- w_alu_result  in  32  ALU output.
- w_mem_data  in  32  load data.
- w_pc_plus1  in  32  PC+1 for jal.
- w_target  in  27  T field for setx.
- w_ovf  in  1  ALU overflow for add/addi/sub.
- md_valid  in  1  multdiv result available.
- md_rd  in  5  multdiv destination.
- md_result  in  32  multdiv product/quotient.
- md_exc  in  1  multdiv exception.
- md_is_div  in  1  1=div, 0=mul.
- md_ready  out  1  FIFO can accept (count < MD_DEPTH).
- w_stall  out  1  combinational; W instruction not consumed this cycle.
- wr_en  out  1  registered regfile write enable.
- wr_reg  out  5  registered write address.
- wr_data  out  32  registered write data.

Behaviour:
- Decode (w_valid=1):
  - R-type 00000 with aluop not mul/div: rd <= w_alu_result.
  - addi 00101: rd <= w_alu_result.
  - lw 01000: rd <= w_mem_data.
  - jal 00011: r31 <= w_pc_plus1.
  - setx 10101: r30 <= zero-extended w_target.
  - All other opcodes (sw, j, jr, bne, blt, bex, R-type mul/div) write nothing; mul/div write only via the md path.
- Writes with address 0 are consumed but wr_en stays 0.
- md handshake: push when md_valid && md_ready, same cycle. md_valid while !md_ready is a protocol error; the data is dropped and the FIFO is unchanged.
- Push and pop in the same cycle are both honoured.
- Arbitration per cycle, producing the next registered write:
  1. FIFO non-empty and (starve_cnt==STARVE_MAX, or FIFO full and W wants a write): pop FIFO head, w_stall=1.
  2. Else W wants a write: W write, w_stall=0; starve_cnt++ (saturating) if FIFO non-empty.
  3. Else FIFO non-empty: pop head, starve_cnt cleared.
  4. Else wr_en=0.
- starve_cnt clears on every pop and whenever the FIFO is empty.
- w_stall is 0 whenever w_valid=0 or the W instruction writes nothing.
- Latency: decision in cycle N appears on wr_* at edge N+1, so one registered stage.
- FIFO is circular; pointers wrap modulo MD_DEPTH. Entries keep {rd, data, exc, is_div}.
- Reset (async, any time, including mid-drain): wr_en=0, wr_reg=0, wr_data=0, FIFO empty, starve_cnt=0, md_ready=1. Pending entries are discarded.

Optional Feature:
- WB_STATUS_EN defined:
  - Overflow redirects the write to r30 with rstatus codes: w_ovf on add gives 1, on addi gives 2, on sub gives 3.
  - md_exc on a popped entry gives r30 <= 4 (mul) or 5 (div).
  - The original rd is not written.
- WB_STATUS_EN undefined: w_ovf and md_exc are ignored and results write normally.

Test Plan:
- Reset: pulse reset_n low mid-cycle with FIFO holding 2 entries -> wr_en=0 immediately, md_ready=1; no pops follow.
- addi: w_opcode=00101, rd=7, alu=0x0000002A -> next edge wr_en=1, wr_reg=7, wr_data=0x2A. Same with rd=0 -> wr_en=0.
- jal: w_pc_plus1=0x100 -> wr_reg=31, wr_data=0x100. setx with T=0x5 -> wr_reg=30, wr_data=5.
- FIFO full: 2 md pushes (rd=3/0x6, rd=4/0x8) while W writes every cycle -> md_ready=0, w_stall=1, head rd=3 written first, then rd=4 after the next forced drain.
- Starvation: 1 md entry plus continuous lw writes -> exactly 3 lw writes, then forced md write with w_stall=1 for one cycle.
- WB_STATUS_EN: sub with w_ovf=1, rd=9 -> wr_reg=30, wr_data=3. div entry with md_exc=1 popped -> wr_reg=30, wr_data=5.
